// File: rtl/muldiv_pkg.sv
// Shared constants for the iterative RV32M/RV64M multiply/divide unit.
// ALUControl also uses the opcode/funct7 pair to decode M-extension ops.
package muldiv_pkg;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [6:0] OPCODE_OP     = 7'b0110011;
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    // funct3[2] separates the divide group from the multiply group.
    function automatic logic is_div_op(input logic [2:0] f3);
        return f3[2];
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the bit-serial datapath: shift-add for multiply,
// restoring shift-subtract for divide.
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] acc,
    input  logic [XLEN-1:0] shreg,
    input  logic [XLEN-1:0] operand,
    input  logic            div_mode,
    output logic [XLEN-1:0] acc_next,
    output logic [XLEN-1:0] shreg_next
);

    logic [XLEN:0]   sum;
    logic [XLEN:0]   rem_sh;
    logic [XLEN-1:0] diff;
    logic            fits;

    always_comb begin
        // Multiply: {acc, shreg} holds the partial product, the multiplier drains out of shreg.
        sum    = {1'b0, acc} + (shreg[0] ? {1'b0, operand} : '0);
        // Divide: acc is the partial remainder, shreg shifts dividend bits out and quotient bits in.
        rem_sh = {acc, shreg[XLEN-1]};
        fits   = (rem_sh >= {1'b0, operand});
        diff   = rem_sh[XLEN-1:0] - operand;

        acc_next   = sum[XLEN:1];
        shreg_next = {sum[0], shreg[XLEN-1:1]};
        if (div_mode) begin
            acc_next   = fits ? diff : rem_sh[XLEN-1:0];
            shreg_next = {shreg[XLEN-2:0], fits};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative M-extension unit: handshake in, XLEN serial steps (or a fast path),
// sign correction, handshake out.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(XLEN - 1);

    function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] v, input logic is_signed);
        logic signed [XLEN-1:0] sv;
        sv = $signed(v);
        if (is_signed && sv < 0) return $unsigned(-sv);
        return v;
    endfunction

    function automatic logic [XLEN-1:0] neg_x(input logic [XLEN-1:0] v, input logic neg);
        return neg ? ('0 - v) : v;
    endfunction

    function automatic logic [2*XLEN-1:0] neg_2x(input logic [2*XLEN-1:0] v, input logic neg);
        return neg ? ('0 - v) : v;
    endfunction

    logic [1:0]        state;
    logic [CNT_W-1:0]  count;
    logic [2:0]        op;
    logic              neg_res;
    logic [XLEN-1:0]   acc;
    logic [XLEN-1:0]   shreg;
    logic [XLEN-1:0]   operand;
    logic [XLEN-1:0]   step_acc;
    logic [XLEN-1:0]   step_shreg;

    logic              accept;
    logic              div_in;
    logic              a_sgn;
    logic              b_sgn;
    logic              a_neg;
    logic              b_neg;
    logic [XLEN-1:0]   mag_a;
    logic [XLEN-1:0]   mag_b;
    logic              fast;
    logic [XLEN-1:0]   fast_result;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   final_result;

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);
    assign busy      = (state != S_IDLE);
    assign accept    = in_valid && in_ready && !flush;

    always_comb begin
        div_in = is_div_op(funct3);
        a_sgn  = (funct3 == OP_MUL) || (funct3 == OP_MULH) || (funct3 == OP_MULHSU)
              || (funct3 == OP_DIV) || (funct3 == OP_REM);
        b_sgn  = (funct3 == OP_MUL) || (funct3 == OP_MULH)
              || (funct3 == OP_DIV) || (funct3 == OP_REM);
        a_neg  = a_sgn && A[XLEN-1];
        b_neg  = b_sgn && B[XLEN-1];
        mag_a  = magnitude(A, a_sgn);
        mag_b  = magnitude(B, b_sgn);

        fast        = 1'b0;
        fast_result = '0;
        if (div_in && B == '0) begin
            fast        = 1'b1;
            fast_result = funct3[1] ? A : '1;
        end else if (!funct3[0] && div_in && A == {1'b1, {(XLEN-1){1'b0}}} && B == '1) begin
            fast        = 1'b1;
            fast_result = funct3[1] ? '0 : A;
        end else if (!div_in && (A == '0 || B == '0)) begin
            fast = 1'b1;
        end
    end

    muldiv_step #(.XLEN(XLEN)) u_step (
        .acc        (acc),
        .shreg      (shreg),
        .operand    (operand),
        .div_mode   (op[2]),
        .acc_next   (step_acc),
        .shreg_next (step_shreg)
    );

    always_comb begin
        prod = neg_2x({step_acc, step_shreg}, neg_res);
        case (op)
            OP_MUL:                       final_result = prod[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: final_result = prod[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              final_result = neg_x(step_shreg, neg_res);
            default:                      final_result = neg_x(step_acc, neg_res);
        endcase
    end

    // Control: FSM, iteration counter and the architecturally visible result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            count  <= '0;
            result <= '0;
        end else if (flush) begin
            state <= S_IDLE;
            count <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        count <= '0;
                        if (fast) begin
                            state  <= S_DONE;
                            result <= fast_result;
                        end else begin
                            state <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    if (count == LAST) begin
                        state  <= S_DONE;
                        result <= final_result;
                        count  <= '0;
                    end else begin
                        count <= count + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    if (out_ready) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Datapath: operand latches and serial registers carry no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            op      <= funct3;
            neg_res <= (div_in && funct3[1]) ? a_neg : (a_neg ^ b_neg);
            acc     <= '0;
            shreg   <= div_in ? mag_a : mag_b;
            operand <= div_in ? mag_b : mag_a;
        end else if (state == S_CALC) begin
            acc   <= step_acc;
            shreg <= step_shreg;
        end
    end

endmodule
